// File: rtl/ex_wb_pipe_ctrl.sv
// Execute-to-Writeback pipeline register with data-memory handshake control.
// Memory ops stall E until dmem_ack or until MAX_WAIT wait cycles elapse.
module ex_wb_pipe_ctrl #(
   parameter int unsigned MAX_WAIT  = 15,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_e,
   input  logic [31:0] pc_e,
   input  logic [31:0] alu_out_e,
   input  logic [31:0] rdata2_e,
   input  logic        reg_wr_e,
   input  logic        br_taken_e,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [31:0] instruction_w,
   output logic [31:0] pc_w,
   output logic [31:0] alu_out_w,
   output logic [31:0] rdata_w,
   output logic        reg_wr_w,
   output logic        stall,
   output logic        flush,
   output logic        mem_err
);

   localparam int unsigned      CntW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   typedef enum logic {StIdle, StWait} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;

   logic [6:0] opcode;
   logic       is_load, is_store, is_mem, is_branch, is_jump;
   logic       timeout, advance, reg_wr_nxt;

   assign opcode    = instruction_e[6:0];
   assign is_load   = (opcode == OpLoad);
   assign is_store  = (opcode == OpStore);
   assign is_mem    = is_load | is_store;
   assign is_branch = (opcode == OpBranch);
   assign is_jump   = (opcode == OpJal) | (opcode == OpJalr);

   // E stays frozen while stalled, so the request simply follows the E opcode.
   always_comb begin
      dmem_req = 1'b0;
      stall    = 1'b0;
      timeout  = 1'b0;
      if (!rst && is_mem) begin
         dmem_req = 1'b1;
         if (!dmem_ack) begin
            if (state_q == StWait && cnt_q == CntMax) begin
               timeout = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
      end
   end

   assign dmem_we    = dmem_req & is_store;
   assign dmem_addr  = alu_out_e;
   assign dmem_wdata = rdata2_e;
   assign flush      = !rst && !stall && ((is_branch && br_taken_e) || is_jump);
   assign advance    = !rst && !stall && !timeout;
   assign reg_wr_nxt = reg_wr_e && !is_store && !is_branch && (instruction_e[11:7] != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (stall) begin
                  state_q <= StWait;
                  cnt_q   <= CntW'(1);
               end
            end
            StWait: begin
               if (stall) begin
                  cnt_q <= cnt_q + CntW'(1);
               end else begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   // Stalled or aborted cycles insert a bubble so no writeback is repeated.
   always_ff @(posedge clk) begin
      if (rst) begin
         instruction_w <= NOP_INSTR;
         pc_w          <= '0;
         alu_out_w     <= '0;
         rdata_w       <= '0;
         reg_wr_w      <= 1'b0;
      end else if (advance) begin
         instruction_w <= instruction_e;
         pc_w          <= pc_e;
         alu_out_w     <= alu_out_e;
         reg_wr_w      <= reg_wr_nxt;
         if (is_load) begin
            rdata_w <= dmem_rdata;
         end
      end else begin
         instruction_w <= NOP_INSTR;
         reg_wr_w      <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_err <= 1'b0;
      end else if (timeout) begin
         mem_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ex_wb_pipe_ctrl.sv
// Directed bench for ex_wb_pipe_ctrl: per-cycle reference model plus literal spot checks.
module tb_ex_wb_pipe_ctrl;

   localparam int          MaxWait = 15;
   localparam logic [31:0] Nop     = 32'h0000_0013;
   localparam logic [31:0] IAdd    = 32'h002082B3;  // add  x5,x1,x2
   localparam logic [31:0] ILw     = 32'h0000A303;  // lw   x6,0(x1)
   localparam logic [31:0] ISw     = 32'h0020A223;  // sw   x2,4(x1)
   localparam logic [31:0] IBeq    = 32'h00208463;  // beq  x1,x2,+8
   localparam logic [31:0] IJal    = 32'h010000EF;  // jal  x1,16
   localparam logic [31:0] IJalr   = 32'h00008067;  // jalr x0,0(x1)
   localparam logic [31:0] IAddiX0 = 32'h00100013;  // addi x0,x0,1

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction_e, pc_e, alu_out_e, rdata2_e, dmem_rdata;
   logic        reg_wr_e, br_taken_e, dmem_ack;
   logic        dmem_req, dmem_we, reg_wr_w, stall, flush, mem_err;
   logic [31:0] dmem_addr, dmem_wdata, instruction_w, pc_w, alu_out_w, rdata_w;

   int n_checks = 0;
   int n_fail   = 0;

   ex_wb_pipe_ctrl #(.MAX_WAIT(MaxWait), .NOP_INSTR(Nop)) dut (
      .clk(clk), .rst(rst), .instruction_e(instruction_e), .pc_e(pc_e),
      .alu_out_e(alu_out_e), .rdata2_e(rdata2_e), .reg_wr_e(reg_wr_e),
      .br_taken_e(br_taken_e), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .instruction_w(instruction_w), .pc_w(pc_w),
      .alu_out_w(alu_out_w), .rdata_w(rdata_w), .reg_wr_w(reg_wr_w),
      .stall(stall), .flush(flush), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic op_is(input logic [31:0] ins, input logic [6:0] op);
      return ins[6:0] == op;
   endfunction
   function automatic logic f_load(input logic [31:0] ins);   return op_is(ins, 7'b0000011); endfunction
   function automatic logic f_store(input logic [31:0] ins);  return op_is(ins, 7'b0100011); endfunction
   function automatic logic f_branch(input logic [31:0] ins); return op_is(ins, 7'b1100011); endfunction
   function automatic logic f_jump(input logic [31:0] ins);
      return op_is(ins, 7'b1101111) || op_is(ins, 7'b1100111);
   endfunction

   // Reference model: m_waited = stall cycles already spent on the current access.
   bit          m_valid = 0;
   int          m_waited;
   logic [31:0] m_iw, m_pcw, m_aluw, m_rdw;
   logic        m_regw, m_err;

   function automatic logic e_req();
      return !rst && (f_load(instruction_e) || f_store(instruction_e));
   endfunction
   function automatic logic e_stall();
      return e_req() && !dmem_ack && (m_waited < MaxWait);
   endfunction
   function automatic logic e_timeout();
      return e_req() && !dmem_ack && (m_waited == MaxWait);
   endfunction
   function automatic logic e_flush();
      return !rst && !e_stall() &&
             ((f_branch(instruction_e) && br_taken_e) || f_jump(instruction_e));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1; m_waited = 0; m_iw = Nop; m_pcw = 0; m_aluw = 0; m_rdw = 0;
         m_regw = 0; m_err = 0;
      end else if (m_valid) begin
         if (e_stall()) begin
            m_waited++; m_iw = Nop; m_regw = 0;
         end else if (e_timeout()) begin
            m_waited = 0; m_iw = Nop; m_regw = 0; m_err = 1;
         end else begin
            m_waited = 0;
            m_iw = instruction_e; m_pcw = pc_e; m_aluw = alu_out_e;
            if (f_load(instruction_e)) m_rdw = dmem_rdata;
            m_regw = reg_wr_e && !f_store(instruction_e) && !f_branch(instruction_e)
                     && (instruction_e[11:7] != 5'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_req", 32'(dmem_req), 32'(e_req()));
         chk("m_we", 32'(dmem_we), 32'(e_req() && f_store(instruction_e)));
         if (e_req()) begin
            chk("m_addr", dmem_addr, alu_out_e);
            chk("m_wdata", dmem_wdata, rdata2_e);
         end
         chk("m_stall", 32'(stall), 32'(e_stall()));
         chk("m_flush", 32'(flush), 32'(e_flush()));
         chk("m_instr_w", instruction_w, m_iw);
         chk("m_pc_w", pc_w, m_pcw);
         chk("m_alu_w", alu_out_w, m_aluw);
         chk("m_rdata_w", rdata_w, m_rdw);
         chk("m_reg_wr_w", 32'(reg_wr_w), 32'(m_regw));
         chk("m_mem_err", 32'(mem_err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] rd2, input logic we, input logic br,
                        input logic ack, input logic [31:0] rdata);
      instruction_e = ins; pc_e = pc; alu_out_e = alu; rdata2_e = rd2;
      reg_wr_e = we; br_taken_e = br; dmem_ack = ack; dmem_rdata = rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      rst = 1'b1;
      set_e(Nop, 0, 0, 0, 0, 0, 0, 0);
      tick();
      // Reset dominates a pending load.
      set_e(ILw, 32'h80, 32'h100, 0, 1, 1, 0, 0);
      #1;
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_instr_w", instruction_w, Nop);
      chk("rst_mem_err", 32'(mem_err), 0);
      tick();
      rst = 1'b0;

      // ALU op, br_taken and stray ack ignored.
      set_e(IAdd, 32'h4, 32'h10, 0, 1, 1, 1, 32'h1234);
      #1;
      chk("add_stall", 32'(stall), 0);
      chk("add_flush", 32'(flush), 0);
      tick();
      chk("add_instr_w", instruction_w, IAdd);
      chk("add_alu_w", alu_out_w, 32'h10);
      chk("add_reg_wr_w", 32'(reg_wr_w), 1);
      chk("add_rdata_w", rdata_w, 0);

      // Load acked after three stall cycles.
      set_e(ILw, 32'h8, 32'h100, 0, 1, 0, 0, 0);
      stalls = 0;
      repeat (3) begin
         #1;
         if (stall) stalls++;
         chk("lw_addr", dmem_addr, 32'h100);
         tick();
         chk("lw_bubble", instruction_w, Nop);
      end
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      chk("lw_ack_stall", 32'(stall), 0);
      tick();
      chk("lw_stalls", 32'(stalls), 3);
      chk("lw_rdata_w", rdata_w, 32'hDEADBEEF);
      chk("lw_reg_wr_w", 32'(reg_wr_w), 1);

      // Store with immediate ack.
      set_e(ISw, 32'hC, 32'h40, 32'h55, 1, 0, 1, 0);
      #1;
      chk("sw_we", 32'(dmem_we), 1);
      chk("sw_wdata", dmem_wdata, 32'h55);
      chk("sw_stall", 32'(stall), 0);
      tick();
      chk("sw_reg_wr_w", 32'(reg_wr_w), 0);
      chk("sw_instr_w", instruction_w, ISw);

      // Load never acked: aborted after MAX_WAIT stall cycles.
      set_e(ILw, 32'h10, 32'h200, 0, 1, 0, 0, 0);
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!stall) break;
         stalls++;
         tick();
      end
      chk("to_stalls", 32'(stalls), 15);
      tick();
      chk("to_mem_err", 32'(mem_err), 1);
      chk("to_instr_w", instruction_w, 32'h00000013);
      set_e(IAdd, 32'h14, 32'h20, 0, 1, 0, 0, 0);
      #1;
      chk("to_idle_req", 32'(dmem_req), 0);
      chk("to_idle_stall", 32'(stall), 0);
      tick();
      chk("to_sticky", 32'(mem_err), 1);

      // Control flow and write-enable masking.
      set_e(IBeq, 32'h18, 0, 0, 1, 1, 0, 0);
      #1; chk("beq_t_flush", 32'(flush), 1);
      tick();
      chk("beq_reg_wr_w", 32'(reg_wr_w), 0);
      set_e(IBeq, 32'h1C, 0, 0, 1, 0, 0, 0);
      #1; chk("beq_nt_flush", 32'(flush), 0);
      tick();
      set_e(IJal, 32'h20, 32'h24, 0, 1, 0, 0, 0);
      #1; chk("jal_flush", 32'(flush), 1);
      tick();
      set_e(IJalr, 32'h24, 32'h28, 0, 1, 0, 0, 0);
      #1; chk("jalr_flush", 32'(flush), 1);
      tick();
      set_e(IAddiX0, 32'h28, 32'h1, 0, 1, 0, 0, 0);
      tick();
      chk("addi_x0_reg_wr_w", 32'(reg_wr_w), 0);

      // Back-to-back memory ops, each with its own wait sequence.
      set_e(ILw, 32'h30, 32'h300, 0, 1, 0, 0, 0);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0001;
      tick();
      set_e(ISw, 32'h34, 32'h304, 32'h77, 0, 0, 0, 0);
      repeat (2) tick();
      dmem_ack = 1'b1;
      #1; chk("b2b_sw_stall", 32'(stall), 0);
      tick();
      chk("b2b_rdata_w", rdata_w, 32'hA5A5_0001);

      // Reset on the second cycle of a wait.
      set_e(ILw, 32'h40, 32'h400, 0, 1, 0, 0, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("rstw_req", 32'(dmem_req), 0);
      chk("rstw_stall", 32'(stall), 0);
      tick();
      rst = 1'b0;
      set_e(Nop, 32'h44, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rstw_req_after", 32'(dmem_req), 0);
      chk("rstw_stall_after", 32'(stall), 0);
      chk("rstw_instr_w", instruction_w, Nop);
      chk("rstw_mem_err", 32'(mem_err), 0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
